avr_pp_responder: RTL and testbench



---
 rtl/avr_pp_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_avr_pp_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/avr_pp_responder.sv
// -----------------------------------------------------------------------------
// avr_pp_responder
//   Device-side model of an AVR high-voltage parallel-programming target
//   (flash only). It decodes XTAL1/PAGEL/WR strobes from the programmer,
//   holds one flash page in a buffer, runs timed page-program and chip-erase
//   busy phases, and returns flash bytes on the data bus under OE.
//
// Ports
//   clk       system clock (>= 4x the fastest control-line toggle)
//   nreset    asynchronous active-low reset
//   xtal      XTAL1 strobe, acts on rising edge
//   xa0, xa1  action select for xtal strobes
//   bs1       byte select (0 low byte, 1 high byte)
//   bs2       reserved, ignored
//   pagel     page-buffer load strobe, acts on rising edge
//   wr_n      write pulse, acts on falling edge
//   oe_n      output enable, active low
//   data_in   data bus from the programmer
//   data_out  registered read data
//   data_oe   drive enable for data_out
//   rdy       1 = ready, 0 = busy programming/erasing
// -----------------------------------------------------------------------------
module avr_pp_responder #(
   parameter int FLASH_WORDS  = 4096,
   parameter int PAGE_WORDS   = 32,
   parameter int PROG_CYCLES  = 64,
   parameter int ERASE_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       xtal,
   input  logic       xa0,
   input  logic       xa1,
   input  logic       bs1,
   input  logic       bs2,
   input  logic       pagel,
   input  logic       wr_n,
   input  logic       oe_n,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       rdy
);

   localparam int AW   = $clog2(FLASH_WORDS);
   localparam int PW   = $clog2(PAGE_WORDS);
   localparam int MAXC = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   localparam logic [CW-1:0] C_PAGE_WORDS  = CW'(PAGE_WORDS);
   localparam logic [CW-1:0] C_FLASH_WORDS = CW'(FLASH_WORDS);
   localparam logic [CW-1:0] C_PROG_LAST   = CW'(PROG_CYCLES - 1);
   localparam logic [CW-1:0] C_ERASE_LAST  = CW'(ERASE_CYCLES - 1);

   localparam logic [7:0] CMD_WRITE = 8'h10;
   localparam logic [7:0] CMD_ERASE = 8'h80;
   localparam logic [7:0] CMD_READ  = 8'h02;

   // Synchronizer bit layout: {xtal, pagel, wr_n, oe_n, xa1, xa0, bs1, data[7:0]}
   // wr_n and oe_n reset to their idle-high level so reset release does not
   // look like a write or an output enable.
   localparam logic [14:0] SYNC_RST = 15'h1800;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROG,
      S_ERASE
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronizer and edge detection
   // ---------------------------------------------------------------------------
   logic [14:0] r_sync1;
   logic [14:0] r_sync2;
   logic [2:0]  r_prev;      // {xtal, pagel, wr_n} one clock behind r_sync2

   logic        w_s_xtal;
   logic        w_s_pagel;
   logic        w_s_wr_n;
   logic        w_s_oe_n;
   logic        w_s_xa1;
   logic        w_s_xa0;
   logic        w_s_bs1;
   logic [7:0]  w_s_data;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_sync1 <= SYNC_RST;
         r_sync2 <= SYNC_RST;
         r_prev  <= 3'b001;
      end else begin
         r_sync1 <= {xtal, pagel, wr_n, oe_n, xa1, xa0, bs1, data_in};
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2[14:12];
      end
   end

   assign w_s_xtal  = r_sync2[14];
   assign w_s_pagel = r_sync2[13];
   assign w_s_wr_n  = r_sync2[12];
   assign w_s_oe_n  = r_sync2[11];
   assign w_s_xa1   = r_sync2[10];
   assign w_s_xa0   = r_sync2[9];
   assign w_s_bs1   = r_sync2[8];
   assign w_s_data  = r_sync2[7:0];

   logic w_xtal_rise;
   logic w_pagel_rise;
   logic w_wr_fall;

   assign w_xtal_rise  = w_s_xtal  & ~r_prev[2];
   assign w_pagel_rise = w_s_pagel & ~r_prev[1];
   assign w_wr_fall    = ~w_s_wr_n &  r_prev[0];

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   logic [15:0] r_flash    [FLASH_WORDS];
   logic [15:0] r_page_buf [PAGE_WORDS];

   // ---------------------------------------------------------------------------
   // Latched address/data/command
   // ---------------------------------------------------------------------------
   logic [7:0]    r_addr_lo;
   logic [7:0]    r_addr_hi;
   logic [7:0]    r_dlo;
   logic [7:0]    r_dhi;
   logic [7:0]    r_cmd;
   logic [15:0]   w_addr16;
   logic [AW-1:0] w_waddr;
   logic          w_unused;

   assign w_addr16 = {r_addr_hi, r_addr_lo};
   assign w_waddr  = w_addr16[AW-1:0];    // upper address bits alias
   assign w_unused = ^{bs2, w_addr16};

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          w_fl_we;
   logic [AW-1:0] w_fl_addr;
   logic [15:0]   w_fl_wdata;
   logic          w_idle;

   assign w_idle = (r_state == S_IDLE);
   assign rdy    = w_idle;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_fl_we     = 1'b0;
      w_fl_addr   = r_count[AW-1:0];
      w_fl_wdata  = 16'hFFFF;
      case (r_state)
         S_IDLE: begin
            // wr_n sees the command latched before this clock, so a cmd load
            // in the same clock does not affect it.
            if (w_wr_fall) begin
               if (r_cmd == CMD_WRITE) begin
                  w_state_nxt = S_PROG;
                  w_count_nxt = '0;
               end else if (r_cmd == CMD_ERASE) begin
                  w_state_nxt = S_ERASE;
                  w_count_nxt = '0;
               end
            end
         end
         S_PROG: begin
            // Page base comes from the latched address; it cannot change while
            // busy because strobes are discarded outside IDLE.
            w_fl_we    = (r_count < C_PAGE_WORDS);
            w_fl_addr  = {w_waddr[AW-1:PW], r_count[PW-1:0]};
            w_fl_wdata = r_page_buf[r_count[PW-1:0]];
            if (r_count == C_PROG_LAST) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = '0;
            end else begin
               w_count_nxt = r_count + CW'(1);
            end
         end
         S_ERASE: begin
            w_fl_we    = (r_count < C_FLASH_WORDS);
            w_fl_addr  = r_count[AW-1:0];
            w_fl_wdata = 16'hFFFF;
            if (r_count == C_ERASE_LAST) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = '0;
            end else begin
               w_count_nxt = r_count + CW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Latches and read path
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_addr_lo <= '0;
         r_addr_hi <= '0;
         r_dlo     <= '0;
         r_dhi     <= '0;
         r_cmd     <= '0;
         data_oe   <= 1'b0;
         data_out  <= '0;
      end else begin
         if (w_idle && w_xtal_rise) begin
            case ({w_s_xa1, w_s_xa0})
               2'b00: begin
                  if (w_s_bs1) r_addr_hi <= w_s_data;
                  else         r_addr_lo <= w_s_data;
               end
               2'b01: begin
                  if (w_s_bs1) r_dhi <= w_s_data;
                  else         r_dlo <= w_s_data;
               end
               2'b10:   r_cmd <= w_s_data;
               default: ;
            endcase
         end
         // Next-state term drops data_oe on the same clock rdy goes low.
         data_oe  <= ~w_s_oe_n && (r_cmd == CMD_READ) && (w_state_nxt == S_IDLE);
         data_out <= w_s_bs1 ? r_flash[w_waddr][15:8] : r_flash[w_waddr][7:0];
      end
   end

   // Memories carry no reset; a reset mid-operation simply stops the writes.
   always_ff @(posedge clk) begin
      if (w_fl_we)
         r_flash[w_fl_addr] <= w_fl_wdata;
   end

   // pagel uses the pre-update data/address when it coincides with an xtal load.
   always_ff @(posedge clk) begin
      if (w_idle && w_pagel_rise && (r_cmd == CMD_WRITE))
         r_page_buf[w_waddr[PW-1:0]] <= {r_dhi, r_dlo};
   end

endmodule

// File: tb/tb_avr_pp_responder.sv
module tb_avr_pp_responder;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       xtal = 1'b0, xa0 = 1'b0, xa1 = 1'b0, bs1 = 1'b0, bs2 = 1'b0;
   logic       pagel = 1'b0, wr_n = 1'b1, oe_n = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       data_oe;
   logic       rdy;

   int checks = 0;
   int errors = 0;

   avr_pp_responder dut (
      .clk(clk), .nreset(nreset), .xtal(xtal), .xa0(xa0), .xa1(xa1),
      .bs1(bs1), .bs2(bs2), .pagel(pagel), .wr_n(wr_n), .oe_n(oe_n),
      .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .rdy(rdy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          use_addr;
      logic [15:0] addr;
      bit          b;
      logic        exp_oe;
      logic [7:0]  exp_d;
   } rd_vec_t;

   rd_vec_t tbl [19];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic xtal_load(input logic a1, input logic a0, input logic b, input logic [7:0] d);
      xa1 = a1; xa0 = a0; bs1 = b; data_in = d;
      tick(3);
      xtal = 1'b1;
      tick(4);
      xtal = 1'b0;
      tick(3);
   endtask

   task automatic pagel_pulse();
      pagel = 1'b1;
      tick(4);
      pagel = 1'b0;
      tick(3);
   endtask

   // Pulse wr_n and count clocks with rdy low; optionally fire an xtal
   // (addr_lo=0x77) and a pagel in the middle of the busy phase.
   task automatic wr_busy(input int exp, input int budget, input bit inject, input string nm);
      int  busy;
      bit  done;
      busy = 0;
      done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (c == 0) wr_n = 1'b0;
         if (c == 6) wr_n = 1'b1;
         if (inject) begin
            if (c == 10) begin xa1 = 1'b0; xa0 = 1'b0; bs1 = 1'b0; data_in = 8'h77; end
            if (c == 14) begin xtal = 1'b1; pagel = 1'b1; end
            if (c == 20) begin xtal = 1'b0; pagel = 1'b0; end
         end
         @(negedge clk);
         if (!rdy) busy++;
         else if (busy > 0) begin
            done = 1'b1;
            break;
         end
      end
      wr_n = 1'b1; xtal = 1'b0; pagel = 1'b0;
      if (exp > 0 && !done) chk({nm, "_timeout"}, busy, -1);
      else                  chk(nm, busy, exp);
      tick(4);
   endtask

   task automatic run_reads(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         if (tbl[k].use_addr) begin
            xtal_load(1'b0, 1'b0, 1'b1, tbl[k].addr[15:8]);
            xtal_load(1'b0, 1'b0, 1'b0, tbl[k].addr[7:0]);
         end
         bs1  = tbl[k].b;
         oe_n = 1'b0;
         tick(6);
         chk($sformatf("rd%0d_oe", k), int'(data_oe), int'(tbl[k].exp_oe));
         chk($sformatf("rd%0d_data", k), int'(data_out), int'(tbl[k].exp_d));
         oe_n = 1'b1;
         tick(4);
      end
   endtask

   initial begin
      // erased reads
      tbl[0]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 8'hFF};
      tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hFF};
      tbl[2]  = '{1'b1, 16'h0FFF, 1'b0, 1'b1, 8'hFF};
      tbl[3]  = '{1'b0, 16'h0FFF, 1'b1, 1'b1, 8'hFF};
      // after page program at 0x0040; first entry reuses latched address 0x005F
      tbl[4]  = '{1'b0, 16'h005F, 1'b0, 1'b1, 8'h1F};
      tbl[5]  = '{1'b1, 16'h0040, 1'b0, 1'b1, 8'h00};
      tbl[6]  = '{1'b0, 16'h0040, 1'b1, 1'b1, 8'hA5};
      tbl[7]  = '{1'b1, 16'h005F, 1'b0, 1'b1, 8'h1F};
      tbl[8]  = '{1'b0, 16'h005F, 1'b1, 1'b1, 8'hA5};
      tbl[9]  = '{1'b1, 16'h0060, 1'b0, 1'b1, 8'hFF};
      tbl[10] = '{1'b0, 16'h0060, 1'b1, 1'b1, 8'hFF};
      // aliased program through 0xFFFF
      tbl[11] = '{1'b1, 16'h0FFF, 1'b0, 1'b1, 8'h3C};
      tbl[12] = '{1'b0, 16'h0FFF, 1'b1, 1'b1, 8'hC3};
      tbl[13] = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 8'h3C};
      tbl[14] = '{1'b1, 16'h0FE0, 1'b1, 1'b1, 8'hA5};
      tbl[15] = '{1'b0, 16'h0FE0, 1'b0, 1'b1, 8'h00};
      // after reset mid-erase
      tbl[16] = '{1'b1, 16'h0004, 1'b0, 1'b1, 8'hFF};
      tbl[17] = '{1'b1, 16'h0FFF, 1'b0, 1'b1, 8'h3C};
      tbl[18] = '{1'b1, 16'h0040, 1'b1, 1'b1, 8'hA5};

      // reset state
      tick(3);
      chk("rst_rdy", int'(rdy), 1);
      chk("rst_oe", int'(data_oe), 0);
      chk("rst_dout", int'(data_out), 0);
      nreset = 1'b1;
      tick(3);

      // chip erase and erased reads
      xtal_load(1'b1, 1'b0, 1'b0, 8'h80);
      wr_busy(4096, 4300, 1'b0, "erase_busy");
      xtal_load(1'b1, 1'b0, 1'b0, 8'h02);
      run_reads(0, 3);

      // load one page at 0x0040..0x005F
      xtal_load(1'b1, 1'b0, 1'b0, 8'h10);
      xtal_load(1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 32; i++) begin
         xtal_load(1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
         xtal_load(1'b0, 1'b1, 1'b0, 8'(i));
         xtal_load(1'b0, 1'b1, 1'b1, 8'hA5);
         pagel_pulse();
      end
      // dlo=0x55 would leak into page_buf if a busy-phase pagel were honoured
      xtal_load(1'b0, 1'b1, 1'b0, 8'h55);
      wr_busy(64, 200, 1'b1, "prog_busy_inject");
      wr_busy(64, 200, 1'b0, "reprog_busy");
      xtal_load(1'b1, 1'b0, 1'b0, 8'h02);
      run_reads(4, 10);

      // alias: 0xFFFF lands on 0x0FFF
      xtal_load(1'b1, 1'b0, 1'b0, 8'h10);
      xtal_load(1'b0, 1'b0, 1'b1, 8'hFF);
      xtal_load(1'b0, 1'b0, 1'b0, 8'hFF);
      xtal_load(1'b0, 1'b1, 1'b0, 8'h3C);
      xtal_load(1'b0, 1'b1, 1'b1, 8'hC3);
      pagel_pulse();
      wr_busy(64, 200, 1'b0, "alias_busy");
      xtal_load(1'b1, 1'b0, 1'b0, 8'h02);
      run_reads(11, 15);

      // data_oe latency: 3 clocks each way
      oe_n = 1'b0;
      tick(2);
      chk("oe_lat_2", int'(data_oe), 0);
      tick(1);
      chk("oe_lat_3", int'(data_oe), 1);
      oe_n = 1'b1;
      tick(2);
      chk("oe_off_2", int'(data_oe), 1);
      tick(1);
      chk("oe_off_3", int'(data_oe), 0);
      tick(3);

      // unknown command: no busy, no drive
      xtal_load(1'b1, 1'b0, 1'b0, 8'h33);
      wr_busy(0, 20, 1'b0, "badcmd_busy");
      oe_n = 1'b0;
      tick(6);
      chk("badcmd_oe", int'(data_oe), 0);
      oe_n = 1'b1;
      tick(4);

      // reset 10 clocks into erase
      begin
         int w;
         w = 0;
         xtal_load(1'b1, 1'b0, 1'b0, 8'h80);
         wr_n = 1'b0;
         while (rdy && w < 20) begin
            tick(1);
            w++;
         end
         chk("erase2_started", int'(rdy), 0);
         wr_n = 1'b1;
         tick(10);
         nreset = 1'b0;
         #1;
         chk("abort_rdy", int'(rdy), 1);
         chk("abort_oe", int'(data_oe), 0);
         chk("abort_dout", int'(data_out), 0);
         tick(2);
         nreset = 1'b1;
         tick(3);
      end
      // cmd back at 0: no read drive, no erase on wr_n
      oe_n = 1'b0;
      tick(6);
      chk("post_rst_oe", int'(data_oe), 0);
      oe_n = 1'b1;
      tick(4);
      wr_busy(0, 20, 1'b0, "post_rst_busy");
      xtal_load(1'b1, 1'b0, 1'b0, 8'h02);
      run_reads(16, 18);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
